tadd_rr_sched: RTL and testbench



---
 rtl/tadd_rr_sched_if.sv | 33 +++
 rtl/tadd_rr_sched.sv | 107 ++++++++++
 tb/tb_tadd_rr_sched.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tadd_rr_sched_if.sv
// Bundle between the round-robin scheduler, its requesters, the shared adder and the result consumer.
// master = scheduler side, slave = environment side (requesters, adder, consumer).
interface tadd_rr_sched_if #(
  parameter int NREQ  = 4,
  parameter int LANES = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;
  localparam int VW  = LANES * WIDTH;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*VW-1:0]   req_a;
  logic [NREQ*VW-1:0]   req_b;
  logic                 dp_en;
  logic [VW-1:0]        dp_a;
  logic [VW-1:0]        dp_b;
  logic [VW-1:0]        dp_y;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [VW-1:0]        rsp_y;

  modport master (
    input  req_valid, req_a, req_b, dp_y, rsp_ready,
    output req_ready, dp_en, dp_a, dp_b, rsp_valid, rsp_id, rsp_y
  );

  modport slave (
    output req_valid, req_a, req_b, dp_y, rsp_ready,
    input  req_ready, dp_en, dp_a, dp_b, rsp_valid, rsp_id, rsp_y
  );
endinterface

// File: rtl/tadd_rr_sched.sv
// Round-robin issue scheduler sharing one LANES x WIDTH vector adder among NREQ requesters.
// Requester tags ride a LAT-deep pipeline kept in lockstep with the adder through dp_en.
module tadd_rr_sched #(
  parameter int NREQ  = 4,
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int LAT   = 1
) (
  input  logic            clock,
  input  logic            reset,
  tadd_rr_sched_if.master bus
);
  localparam int IDW = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;
  localparam int VW  = LANES * WIDTH;

  logic [IDW-1:0]          ptr_q;
  logic [IDW-1:0]          ptr_d;
  logic [LAT-1:0]          tag_vld_q;
  logic [LAT-1:0]          tag_vld_d;
  logic [LAT-1:0][IDW-1:0] tag_id_q;
  logic [LAT-1:0][IDW-1:0] tag_id_d;

  logic                    stall_s;
  logic                    dp_en_s;
  logic                    found_s;
  logic                    fire_s;
  logic [IDW-1:0]          gidx_s;
  logic [IDW-1:0]          cand_s;
  logic [NREQ-1:0]         grant_s;

  // Arbitration, issue muxing, tag-pipeline next state and response outputs
  always_comb begin
    stall_s = tag_vld_q[LAT-1] & ~bus.rsp_ready;
    dp_en_s = reset & ~stall_s;

    found_s = 1'b0;
    gidx_s  = {IDW{1'b0}};
    cand_s  = {IDW{1'b0}};
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IDW'((int'(ptr_q) + k) % NREQ);
      if (!found_s && bus.req_valid[cand_s]) begin
        found_s = 1'b1;
        gidx_s  = cand_s;
      end else begin
        found_s = found_s;
        gidx_s  = gidx_s;
      end
    end

    grant_s = {NREQ{1'b0}};
    if (found_s) begin
      grant_s[gidx_s] = 1'b1;
    end else begin
      grant_s = {NREQ{1'b0}};
    end

    // A granted requester is always valid, so ready on it is the fire condition.
    fire_s = found_s & dp_en_s;

    if (found_s) begin
      bus.dp_a = bus.req_a[int'(gidx_s) * VW +: VW];
      bus.dp_b = bus.req_b[int'(gidx_s) * VW +: VW];
    end else begin
      bus.dp_a = {VW{1'b0}};
      bus.dp_b = {VW{1'b0}};
    end

    bus.req_ready = grant_s & {NREQ{dp_en_s}};
    bus.dp_en     = dp_en_s;
    bus.rsp_valid = tag_vld_q[LAT-1];
    bus.rsp_id    = tag_id_q[LAT-1];
    bus.rsp_y     = bus.dp_y;

    if (fire_s) begin
      ptr_d = gidx_s;
    end else begin
      ptr_d = ptr_q;
    end

    tag_vld_d = tag_vld_q;
    tag_id_d  = tag_id_q;
    if (dp_en_s) begin
      tag_vld_d[0] = fire_s;
      tag_id_d[0]  = gidx_s;
      for (int i = 1; i < LAT; i++) begin
        tag_vld_d[i] = tag_vld_q[i-1];
        tag_id_d[i]  = tag_id_q[i-1];
      end
    end else begin
      tag_vld_d = tag_vld_q;
      tag_id_d  = tag_id_q;
    end
  end

  // State registers; pointer resets to NREQ-1 so requester 0 wins first
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q     <= IDW'(NREQ - 1);
      tag_vld_q <= {LAT{1'b0}};
      tag_id_q  <= {(LAT*IDW){1'b0}};
    end else begin
      ptr_q     <= ptr_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end
endmodule

// File: tb/tb_tadd_rr_sched.sv
// Bench for tadd_rr_sched: LAT=1 and LAT=3 instances share stimulus and are checked
// against a scoreboard of issued vectors stamped with the adder-advance count at which they are due.
module tb_tadd_rr_sched;
  localparam int NREQ  = 4;
  localparam int LANES = 4;
  localparam int WIDTH = 8;
  localparam int VW    = LANES * WIDTH;
  localparam int QD    = 64;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*VW-1:0] req_a = '0;
  logic [NREQ*VW-1:0] req_b = '0;
  logic              rsp_ready = 1'b1;
  int                errors = 0;
  int                checks = 0;

  always #5 clock = ~clock;

  tadd_rr_sched_if #(.NREQ(NREQ), .LANES(LANES), .WIDTH(WIDTH)) if1 ();
  tadd_rr_sched_if #(.NREQ(NREQ), .LANES(LANES), .WIDTH(WIDTH)) if3 ();

  tadd_rr_sched #(.NREQ(NREQ), .LANES(LANES), .WIDTH(WIDTH), .LAT(1)) u_lat1 (
    .clock(clock), .reset(reset), .bus(if1.master));
  tadd_rr_sched #(.NREQ(NREQ), .LANES(LANES), .WIDTH(WIDTH), .LAT(3)) u_lat3 (
    .clock(clock), .reset(reset), .bus(if3.master));

  assign if1.req_valid = req_valid;
  assign if1.req_a     = req_a;
  assign if1.req_b     = req_b;
  assign if1.rsp_ready = rsp_ready;
  assign if3.req_valid = req_valid;
  assign if3.req_a     = req_a;
  assign if3.req_b     = req_b;
  assign if3.rsp_ready = rsp_ready;

  // Behavioural adders with enable-held pipelines.
  function automatic logic [VW-1:0] lane_add(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    for (int j = 0; j < LANES; j++) r[j*WIDTH +: WIDTH] = a[j*WIDTH +: WIDTH] + b[j*WIDTH +: WIDTH];
    return r;
  endfunction

  logic [VW-1:0] y1 = '0;
  logic [VW-1:0] y3a = '0;
  logic [VW-1:0] y3b = '0;
  logic [VW-1:0] y3c = '0;
  always @(posedge clock) if (if1.dp_en) y1 <= lane_add(if1.dp_a, if1.dp_b);
  always @(posedge clock) if (if3.dp_en) begin
    y3a <= lane_add(if3.dp_a, if3.dp_b);
    y3b <= y3a;
    y3c <= y3b;
  end
  assign if1.dp_y = y1;
  assign if3.dp_y = y3c;

  logic [NREQ-1:0] o_ready [2];
  logic            o_en [2];
  logic [VW-1:0]   o_dpa [2];
  logic [VW-1:0]   o_dpb [2];
  logic            o_rvalid [2];
  logic [1:0]      o_id [2];
  logic [VW-1:0]   o_y [2];
  assign o_ready[0] = if1.req_ready;  assign o_ready[1] = if3.req_ready;
  assign o_en[0]    = if1.dp_en;      assign o_en[1]    = if3.dp_en;
  assign o_dpa[0]   = if1.dp_a;       assign o_dpa[1]   = if3.dp_a;
  assign o_dpb[0]   = if1.dp_b;       assign o_dpb[1]   = if3.dp_b;
  assign o_rvalid[0] = if1.rsp_valid; assign o_rvalid[1] = if3.rsp_valid;
  assign o_id[0]    = if1.rsp_id;     assign o_id[1]    = if3.rsp_id;
  assign o_y[0]     = if1.rsp_y;      assign o_y[1]     = if3.rsp_y;

  // Reference model state: RR pointer, adder-advance count, in-order scoreboard.
  int            mptr [2];
  int            adv [2];
  int            hd [2];
  int            tl [2];
  int            mb_id [2][QD];
  logic [VW-1:0] mb_y [2][QD];
  int            mb_due [2][QD];
  int            rsps [2];

  logic            exp_rvalid [2];
  int              exp_id [2];
  logic [VW-1:0]   exp_y [2];
  logic            exp_en [2];
  logic            exp_found [2];
  int              exp_g [2];
  logic [NREQ-1:0] exp_ready [2];
  logic [VW-1:0]   exp_dpa [2];
  logic [VW-1:0]   exp_dpb [2];

  function automatic int lat_of(input int m);
    return (m == 0) ? 1 : 3;
  endfunction

  function automatic logic [VW-1:0] ref_sum(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    int s;
    r = '0;
    for (int j = 0; j < LANES; j++) begin
      s = int'($signed(a[j*WIDTH +: WIDTH])) + int'($signed(b[j*WIDTH +: WIDTH]));
      if (s > 127) s = s - 256;
      if (s < -128) s = s + 256;
      r[j*WIDTH +: WIDTH] = 8'(s);
    end
    return r;
  endfunction

  task automatic eval_model();
    for (int m = 0; m < 2; m++) begin
      exp_rvalid[m] = (tl[m] != hd[m]) && (mb_due[m][hd[m] % QD] == adv[m]);
      exp_id[m]     = mb_id[m][hd[m] % QD];
      exp_y[m]      = mb_y[m][hd[m] % QD];
      exp_en[m]     = reset && !(exp_rvalid[m] && !rsp_ready);
      exp_found[m]  = 1'b0;
      exp_g[m]      = 0;
      for (int k = 1; k <= NREQ; k++) begin
        int c = (mptr[m] + k) % NREQ;
        if (!exp_found[m] && req_valid[c]) begin
          exp_found[m] = 1'b1;
          exp_g[m] = c;
        end
      end
      exp_ready[m] = (exp_found[m] && exp_en[m]) ? NREQ'(1 << exp_g[m]) : '0;
      exp_dpa[m]   = exp_found[m] ? req_a[exp_g[m]*VW +: VW] : '0;
      exp_dpb[m]   = exp_found[m] ? req_b[exp_g[m]*VW +: VW] : '0;
    end
  endtask

  task automatic refresh(input int i);
    req_a[i*VW +: VW] = VW'($urandom());
    req_b[i*VW +: VW] = VW'($urandom());
  endtask

  task automatic advance();
    logic [NREQ-1:0] fb;
    fb = exp_ready[0] & exp_ready[1] & req_valid;
    for (int m = 0; m < 2; m++) if (o_rvalid[m] === 1'b1 && rsp_ready) rsps[m]++;
    @(posedge clock);
    for (int m = 0; m < 2; m++) begin
      if (!reset) begin
        mptr[m] = NREQ - 1; adv[m] = 0; hd[m] = 0; tl[m] = 0;
      end else begin
        if (exp_rvalid[m] && rsp_ready) hd[m]++;
        if (exp_en[m]) begin
          if (exp_found[m]) begin
            mb_id[m][tl[m] % QD]  = exp_g[m];
            mb_y[m][tl[m] % QD]   = ref_sum(req_a[exp_g[m]*VW +: VW], req_b[exp_g[m]*VW +: VW]);
            mb_due[m][tl[m] % QD] = adv[m] + lat_of(m);
            tl[m]++;
            mptr[m] = exp_g[m];
          end
          adv[m]++;
        end
      end
    end
    @(negedge clock);
    for (int i = 0; i < NREQ; i++) if (fb[i]) refresh(i);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    eval_model(); #1;
    advance();
    reset = 1'b1;
    rsps[0] = 0; rsps[1] = 0;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) refresh(i);
    do_reset();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      eval_model(); #1;
      for (int m = 0; m < 2; m++) begin
        checks++; if (o_ready[m] !== 4'b0000) begin errors++; $display("FAIL reset_ready lat%0d: got %b want 0000", lat_of(m), o_ready[m]); end
        checks++; if (o_en[m] !== 1'b0) begin errors++; $display("FAIL reset_dp_en lat%0d: got %b want 0", lat_of(m), o_en[m]); end
        checks++; if (o_rvalid[m] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid lat%0d: got %b want 0", lat_of(m), o_rvalid[m]); end
      end
      advance();
    end
    reset = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001; rsp_ready = 1'b1;
    req_a[31:0] = 32'hFD1C0807;
    req_b[31:0] = 32'h08010F03;
    eval_model(); #1;
    for (int m = 0; m < 2; m++) begin
      checks++; if (o_ready[m] !== 4'b0001 || o_dpa[m] !== 32'hFD1C0807 || o_dpb[m] !== 32'h08010F03) begin
        errors++; $display("FAIL single_issue lat%0d: got ready=%b a=%h b=%h want 0001 fd1c0807 08010f03", lat_of(m), o_ready[m], o_dpa[m], o_dpb[m]);
      end
    end
    advance();
    req_valid = 4'b0000;
    for (int c = 1; c <= 4; c++) begin
      eval_model(); #1;
      checks++; if (o_rvalid[0] !== (c == 1)) begin errors++; $display("FAIL single_valid lat1 c%0d: got %b want %b", c, o_rvalid[0], c == 1); end
      checks++; if (o_rvalid[1] !== (c == 3)) begin errors++; $display("FAIL single_valid lat3 c%0d: got %b want %b", c, o_rvalid[1], c == 3); end
      if (c == 1) begin
        checks++; if (o_id[0] !== 2'd0 || o_y[0] !== 32'h051D170A) begin errors++; $display("FAIL single_rsp lat1: got id=%0d y=%h want 0 051d170a", o_id[0], o_y[0]); end
      end
      if (c == 3) begin
        checks++; if (o_id[1] !== 2'd0 || o_y[1] !== 32'h051D170A) begin errors++; $display("FAIL single_rsp lat3: got id=%0d y=%h want 0 051d170a", o_id[1], o_y[1]); end
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] want;
    do_reset();
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      eval_model(); #1;
      want = NREQ'(1 << (c % NREQ));
      checks++; if (o_ready[0] !== want || o_ready[1] !== want) begin errors++; $display("FAIL rr_grant c%0d: got %b/%b want %b", c, o_ready[0], o_ready[1], want); end
      if (c >= 1) begin
        checks++; if (o_rvalid[0] !== 1'b1 || o_id[0] !== 2'((c - 1) % NREQ) || o_y[0] !== exp_y[0]) begin
          errors++; $display("FAIL rr_rsp lat1 c%0d: got v=%b id=%0d y=%h want 1 %0d %h", c, o_rvalid[0], o_id[0], o_y[0], (c - 1) % NREQ, exp_y[0]);
        end
      end
      if (c >= 3) begin
        checks++; if (o_rvalid[1] !== 1'b1 || o_id[1] !== 2'((c - 3) % NREQ) || o_y[1] !== exp_y[1]) begin
          errors++; $display("FAIL rr_rsp lat3 c%0d: got v=%b id=%0d y=%h want 1 %0d %h", c, o_rvalid[1], o_id[1], o_y[1], (c - 3) % NREQ, exp_y[1]);
        end
      end
      advance();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int            hold_id [2];
    logic [VW-1:0] hold_y [2];
    do_reset();
    req_valid = 4'b1111;
    for (int c = 0; c < 14; c++) begin
      rsp_ready = !(c >= 4 && c <= 6);
      eval_model(); #1;
      for (int m = 0; m < 2; m++) begin
        if (c == 4) begin hold_id[m] = exp_id[m]; hold_y[m] = exp_y[m]; end
        if (c >= 4 && c <= 6) begin
          checks++; if (o_en[m] !== 1'b0 || o_ready[m] !== 4'b0000 || o_rvalid[m] !== 1'b1 || o_id[m] !== 2'(hold_id[m]) || o_y[m] !== hold_y[m]) begin
            errors++; $display("FAIL bp_hold lat%0d c%0d: got en=%b rdy=%b v=%b id=%0d y=%h want 0 0000 1 %0d %h",
                               lat_of(m), c, o_en[m], o_ready[m], o_rvalid[m], o_id[m], o_y[m], hold_id[m], hold_y[m]);
          end
        end else begin
          checks++; if (o_ready[m] !== exp_ready[m] || o_rvalid[m] !== exp_rvalid[m] || (exp_rvalid[m] && (o_id[m] !== 2'(exp_id[m]) || o_y[m] !== exp_y[m]))) begin
            errors++; $display("FAIL bp_flow lat%0d c%0d: got rdy=%b v=%b id=%0d y=%h want %b %b %0d %h",
                               lat_of(m), c, o_ready[m], o_rvalid[m], o_id[m], o_y[m], exp_ready[m], exp_rvalid[m], exp_id[m], exp_y[m]);
          end
        end
      end
      advance();
    end
    req_valid = '0; rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin eval_model(); #1; advance(); end
    eval_model(); #1;
    for (int m = 0; m < 2; m++) begin
      checks++; if (rsps[m] !== tl[m] || o_rvalid[m] !== 1'b0) begin
        errors++; $display("FAIL bp_count lat%0d: got %0d responses valid=%b want %0d 0", lat_of(m), rsps[m], o_rvalid[m], tl[m]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req_valid = 4'b0001; rsp_ready = 1'b1;
    req_a[15:0] = 16'h807F;
    req_b[15:0] = 16'hFF01;
    for (int c = 0; c < 4; c++) begin
      eval_model(); #1;
      if (c == 1) begin
        checks++; if (o_rvalid[0] !== 1'b1 || o_y[0][15:0] !== 16'h7F80 || o_y[0] !== exp_y[0]) begin
          errors++; $display("FAIL wrap lat1: got v=%b y=%h want 1 %h (low 7f80)", o_rvalid[0], o_y[0], exp_y[0]);
        end
      end
      if (c == 3) begin
        checks++; if (o_rvalid[1] !== 1'b1 || o_y[1][15:0] !== 16'h7F80 || o_y[1] !== exp_y[1]) begin
          errors++; $display("FAIL wrap lat3: got v=%b y=%h want 1 %h (low 7f80)", o_rvalid[1], o_y[1], exp_y[1]);
        end
      end
      advance();
      req_valid = 4'b0000;
    end
  endtask

  task automatic test_fairness();
    int wait_n [NREQ];
    int fire_hist [32];
    int g;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) wait_n[i] = 0;
    for (int c = 0; c < 24; c++) begin
      req_valid = 4'b1010 | ((c % 2 == 1) ? 4'b0100 : 4'b0000);
      eval_model(); #1;
      fire_hist[c] = (exp_ready[1] != '0) ? exp_g[1] : -1;
      checks++; if (o_ready[1] !== exp_ready[1]) begin errors++; $display("FAIL fair_grant c%0d: got %b want %b", c, o_ready[1], exp_ready[1]); end
      if (c >= 3) begin
        checks++; if (o_rvalid[1] !== (fire_hist[c-3] != -1) || (fire_hist[c-3] != -1 && o_id[1] !== 2'(fire_hist[c-3]))) begin
          errors++; $display("FAIL fair_latency c%0d: got v=%b id=%0d want fire id %0d", c, o_rvalid[1], o_id[1], fire_hist[c-3]);
        end
      end
      g = -1;
      for (int i = 0; i < NREQ; i++) if (o_ready[1][i] === 1'b1) g = i;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || g == i) wait_n[i] = 0;
        else if (g != -1) wait_n[i]++;
        checks++; if (wait_n[i] > NREQ - 1) begin errors++; $display("FAIL fair_wait req%0d c%0d: got %0d want <= %0d", i, c, wait_n[i], NREQ - 1); end
      end
      advance();
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] nv;
    do_reset();
    pend = '0;
    for (int c = 0; c < 200; c++) begin
      nv = NREQ'($urandom());
      for (int i = 0; i < NREQ; i++) if (!pend[i] && nv[i]) refresh(i);
      req_valid = pend | nv;
      rsp_ready = ($urandom_range(0, 3) != 0);
      eval_model(); #1;
      for (int m = 0; m < 2; m++) begin
        checks++; if (o_ready[m] !== exp_ready[m] || o_en[m] !== exp_en[m]) begin
          errors++; $display("FAIL rand_ctl lat%0d c%0d: got rdy=%b en=%b want %b %b", lat_of(m), c, o_ready[m], o_en[m], exp_ready[m], exp_en[m]);
        end
        checks++; if (o_dpa[m] !== exp_dpa[m] || o_dpb[m] !== exp_dpb[m]) begin
          errors++; $display("FAIL rand_issue lat%0d c%0d: got %h %h want %h %h", lat_of(m), c, o_dpa[m], o_dpb[m], exp_dpa[m], exp_dpb[m]);
        end
        checks++; if (o_rvalid[m] !== exp_rvalid[m]) begin
          errors++; $display("FAIL rand_valid lat%0d c%0d: got %b want %b", lat_of(m), c, o_rvalid[m], exp_rvalid[m]);
        end
        if (exp_rvalid[m]) begin
          checks++; if (o_id[m] !== 2'(exp_id[m]) || o_y[m] !== exp_y[m]) begin
            errors++; $display("FAIL rand_rsp lat%0d c%0d: got id=%0d y=%h want %0d %h", lat_of(m), c, o_id[m], o_y[m], exp_id[m], exp_y[m]);
          end
        end
      end
      pend = req_valid & ~(exp_ready[0] & exp_ready[1]);
      advance();
    end
    req_valid = '0; rsp_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin eval_model(); #1; advance(); end
    reset = 1'b0;
    eval_model(); #1;
    for (int m = 0; m < 2; m++) begin
      checks++; if (o_en[m] !== 1'b0 || o_ready[m] !== 4'b0000) begin errors++; $display("FAIL midrst_gate lat%0d: got en=%b rdy=%b want 0 0000", lat_of(m), o_en[m], o_ready[m]); end
    end
    advance();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      eval_model(); #1;
      if (c == 0) begin
        for (int m = 0; m < 2; m++) begin
          checks++; if (o_ready[m] !== 4'b0001) begin errors++; $display("FAIL midrst_first lat%0d: got %b want 0001", lat_of(m), o_ready[m]); end
        end
      end
      checks++; if (o_rvalid[0] !== (c >= 1)) begin errors++; $display("FAIL midrst_valid lat1 c%0d: got %b want %b", c, o_rvalid[0], c >= 1); end
      checks++; if (o_rvalid[1] !== (c >= 3)) begin errors++; $display("FAIL midrst_valid lat3 c%0d: got %b want %b", c, o_rvalid[1], c >= 3); end
      if (c == 3) begin
        checks++; if (o_id[1] !== 2'd0 || o_y[1] !== exp_y[1]) begin errors++; $display("FAIL midrst_rsp lat3: got id=%0d y=%h want 0 %h", o_id[1], o_y[1], exp_y[1]); end
      end
      advance();
    end
    req_valid = '0;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      mptr[m] = NREQ - 1; adv[m] = 0; hd[m] = 0; tl[m] = 0; rsps[m] = 0;
      exp_rvalid[m] = 1'b0; exp_en[m] = 1'b0; exp_found[m] = 1'b0; exp_ready[m] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_fairness();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
